// File: rtl/decodec_pipe_if.sv
// Instruction-in / decoded-bundle-out channel of the pipelined decoder.
// The master side is the fetch/consumer environment; the slave side is the decoder.
interface decodec_pipe_if #(
  parameter int IW   = 16,
  parameter int OPW  = 6,
  parameter int AW   = 10,
  parameter int BW   = 6,
  parameter int IMMW = 8,
  parameter int FW   = 3
);
  logic [IW-1:0]   in;
  logic [FW-1:0]   flagA;
  logic [FW-1:0]   flagB;
  logic            in_valid;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  opCode;
  logic [1:0]      selA;
  logic [1:0]      selB;
  logic            selM1;
  logic            selM2;
  logic            wrEnable;
  logic            jmpEnable;
  logic            branchEnable;
  logic [IMMW-1:0] inm;
  logic [AW-1:0]   memDir;
  logic [AW-1:0]   jmpDir;
  logic [BW-1:0]   branchDir;
  logic            squashing;

  modport master (
    output in, flagA, flagB, in_valid, out_ready,
    input  in_ready, out_valid, opCode, selA, selB, selM1, selM2,
           wrEnable, jmpEnable, branchEnable, inm, memDir, jmpDir,
           branchDir, squashing
  );

  modport slave (
    input  in, flagA, flagB, in_valid, out_ready,
    output in_ready, out_valid, opCode, selA, selB, selM1, selM2,
           wrEnable, jmpEnable, branchEnable, inm, memDir, jmpDir,
           branchDir, squashing
  );
endinterface

// File: rtl/decodec_pipe.sv
// Pipelined instruction decoder: decodes the opcode class into datapath
// selects/enables, evaluates branch conditions against two flag vectors,
// registers the bundle behind a valid/ready output stage, and drops a
// configurable number of shadow instructions after a taken jump/branch.
module decodec_pipe #(
  parameter int IW     = 16,
  parameter int OPW    = 6,
  parameter int AW     = 10,
  parameter int BW     = 6,
  parameter int IMMW   = 8,
  parameter int FW     = 3,
  parameter int CW     = 2,
  parameter int SQUASH = 1
) (
  input logic clk,
  input logic reset,
  decodec_pipe_if.slave bus
);

  localparam logic [3:0] SQUASH_LOAD = 4'(SQUASH);

  logic [OPW-1:0] opcode;
  logic [1:0]     opClass;
  logic [CW-1:0]  condIdx;
  logic [FW-1:0]  condVector;
  logic           taken;
  logic           decWr;
  logic           decM1;
  logic           decM2;
  logic           decJmp;
  logic           decBr;
  logic           accept;
  logic           drop;
  logic [3:0]     cnt;
  logic [3:0]     cntNext;

  assign opcode  = bus.in[IW-1 -: OPW];
  assign opClass = opcode[OPW-1 -: 2];
  assign condIdx = bus.in[BW +: CW];

  // While squashing the decoder swallows instructions without touching the
  // output stage, so it can always accept then.
  assign drop         = (cnt != 4'd0);
  assign bus.in_ready = drop | ~bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // Branch condition: pick a flag vector and a bit in it; an index past the
  // end of the vector means the branch is unconditional.
  always_comb begin
    condVector = bus.in[BW+CW] ? bus.flagB : bus.flagA;
    taken      = 1'b1;
    for (int i = 0; i < FW; i++) begin
      if (int'(condIdx) == i) taken = condVector[i];
    end
  end

  // Opcode class decode into write/mux/control enables.
  always_comb begin
    decWr  = 1'b0;
    decM1  = 1'b0;
    decM2  = 1'b0;
    decJmp = 1'b0;
    decBr  = 1'b0;
    unique case (opClass)
      2'b00: decWr = 1'b1;
      2'b01: begin
        decWr = 1'b1;
        decM2 = 1'b1;
      end
      2'b10: begin
        decWr = ~opcode[0];
        decM1 = ~opcode[0];
      end
      default: begin
        decJmp = ~opcode[0];
        decBr  = opcode[0] & taken;
      end
    endcase
  end

  // Squash counter: count down on every dropped instruction, reload only on
  // a control transfer that actually reaches the output stage.
  always_comb begin
    cntNext = cnt;
    if (accept) begin
      if (drop) cntNext = cnt - 4'd1;
      else if (decJmp | decBr) cntNext = SQUASH_LOAD;
    end
  end

  // Squash counter and its registered non-zero indicator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt           <= 4'd0;
      bus.squashing <= 1'b0;
    end else begin
      cnt           <= cntNext;
      bus.squashing <= (cntNext != 4'd0);
    end
  end

  // Output stage: load on a kept accept, otherwise hold; valid drops once
  // the consumer takes the bundle and nothing new replaces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid    <= 1'b0;
      bus.opCode       <= '0;
      bus.selA         <= 2'b00;
      bus.selB         <= 2'b00;
      bus.selM1        <= 1'b0;
      bus.selM2        <= 1'b0;
      bus.wrEnable     <= 1'b0;
      bus.jmpEnable    <= 1'b0;
      bus.branchEnable <= 1'b0;
      bus.inm          <= '0;
      bus.memDir       <= '0;
      bus.jmpDir       <= '0;
      bus.branchDir    <= '0;
    end else if (accept && !drop) begin
      bus.out_valid    <= 1'b1;
      bus.opCode       <= opcode;
      bus.selA         <= opcode[3:2];
      bus.selB         <= opcode[1:0];
      bus.selM1        <= decM1;
      bus.selM2        <= decM2;
      bus.wrEnable     <= decWr;
      bus.jmpEnable    <= decJmp;
      bus.branchEnable <= decBr;
      bus.inm          <= bus.in[IMMW-1:0];
      bus.memDir       <= bus.in[AW-1:0];
      bus.jmpDir       <= bus.in[AW-1:0];
      bus.branchDir    <= bus.in[BW-1:0];
    end else if (bus.out_ready) begin
      bus.out_valid    <= 1'b0;
    end
  end

endmodule
